// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment encoding for the seven-segment scanner
package seven_seg_pkg;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: hex nibble to active-low gfedcba segments
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    // table lookup, one glyph per nibble
    always_comb seg = SEG_TABLE[nib];
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed hex display driver with blanking, blink, dp and leading-zero suppression
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_scan: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan
        $error("seven_seg_scan: SCAN_DIV must be >= 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("seven_seg_scan: BLINK_DIV must be >= 2");
    end

    logic [SW-1:0]           scan_cnt;
    logic [BW-1:0]           blink_cnt;
    logic [IW-1:0]           idx;
    logic                    phase;
    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_lz;
    logic                    scan_tc;
    logic                    blink_tc;
    logic                    idx_last;
    logic [3:0]              nib;
    logic [6:0]              dec;
    logic                    lz;
    logic                    off;

    seven_seg_decode u_dec (
        .nib (nib),
        .seg (dec)
    );

    // selected digit: nibble, leading-zero test and overall blanking decision
    always_comb begin
        scan_tc  = scan_cnt == SW'(SCAN_DIV - 1);
        blink_tc = blink_cnt == BW'(BLINK_DIV - 1);
        idx_last = idx == IW'(NUM_DIGITS - 1);
        nib      = sh_value[4*idx +: 4];
        lz       = sh_lz && idx != '0 && (sh_value >> (4*idx)) == '0;
        off      = sh_blank[idx] | (sh_blink[idx] & phase) | lz;
    end

    // scan/blink timebase and shadow capture; load and index advance may share an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            sh_value  <= '0;
            sh_blank  <= '0;
            sh_blink  <= '0;
            sh_dp     <= '0;
            sh_lz     <= 1'b0;
        end else begin
            scan_cnt  <= scan_tc ? '0 : scan_cnt + 1'b1;
            idx       <= scan_tc ? (idx_last ? '0 : idx + 1'b1) : idx;
            blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
            phase     <= blink_tc ? ~phase : phase;
            if (load) begin
                sh_value <= value;
                sh_blank <= blank_mask;
                sh_blink <= blink_mask;
                sh_dp    <= dp_mask;
                sh_lz    <= lz_en;
            end
        end
    end

    // registered display outputs, recomputed every cycle from the current state
    always_ff @(posedge clk) begin
        if (reset) begin
            seg         <= SEG_OFF;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            seg         <= off ? SEG_OFF : dec;
            dp_n        <= off | ~sh_dp[idx];
            an_n        <= ~(NUM_DIGITS'(1) << idx);
            frame_start <= idx == '0 && scan_cnt == '0;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: randomized self-checking bench against a cycle-count reference model
module tb_seven_seg_scan;
    localparam int N     = 4;
    localparam int SCAN  = 4;
    localparam int BLINK = 32;
    localparam logic [6:0] TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [15:0]  value = '0;
    logic [3:0]   blank_mask = '0;
    logic [3:0]   blink_mask = '0;
    logic [3:0]   dp_mask = '0;
    logic         lz_en = 1'b0;
    logic [6:0]   seg;
    logic         dp_n;
    logic [3:0]   an_n;
    logic         frame_start;

    int pass_cnt = 0;
    int total_cnt = 0;

    seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .lz_en       (lz_en),
        .seg         (seg),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Reference model: k counts non-reset edges; digit, blink phase and frame
    // position are plain arithmetic on k, and the display contents are the
    // most recently loaded fields.
    int          k = 0;
    logic [15:0] m_value = '0;
    logic [3:0]  m_blank = '0, m_blink = '0, m_dp = '0;
    logic        m_lz = 1'b0;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_fs;

    always @(posedge clk) begin
        int  d;
        bit  ph, lz, off;
        if (reset) begin
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
            exp_an  = 4'b1111;
            exp_fs  = 1'b0;
            k = 0;
            m_value = '0;
            m_blank = '0;
            m_blink = '0;
            m_dp    = '0;
            m_lz    = 1'b0;
        end else begin
            d   = (k / SCAN) % N;
            ph  = ((k / BLINK) % 2) == 1;
            lz  = m_lz && d > 0 && (m_value >> (4 * d)) == 16'd0;
            off = m_blank[d] || (m_blink[d] && ph) || lz;
            exp_seg = off ? 7'b1111111 : TBL[m_value[4*d +: 4]];
            exp_dp  = off ? 1'b1 : !m_dp[d];
            exp_an  = ~(4'b0001 << d);
            exp_fs  = (k % (SCAN * N)) == 0;
            k++;
            if (load) begin
                m_value = value;
                m_blank = blank_mask;
                m_blink = blink_mask;
                m_dp    = dp_mask;
                m_lz    = lz_en;
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] bk,
                           input logic [3:0] dm, input logic lz);
        @(negedge clk);
        load = 1'b1;
        value = v;
        blank_mask = bm;
        blink_mask = bk;
        dp_mask = dm;
        lz_en = lz;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({seg, dp_n, an_n, frame_start} !== {7'b1111111, 1'b1, 4'b1111, 1'b0})
                $display("FAIL reset: got seg=%b dp_n=%b an_n=%b fs=%b, required 1111111/1/1111/0",
                         seg, dp_n, an_n, frame_start);
            else pass_cnt++;
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] ans [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] sgs [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        int last = -1;
        do_load(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({seg, dp_n, an_n, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs})
                $display("FAIL scan_model: got %b/%b/%b/%b, required %b/%b/%b/%b",
                         seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            else pass_cnt++;
            if (c >= 1) begin
                for (int j = 0; j < 4; j++) begin
                    if (an_n == ans[j]) begin
                        total_cnt++;
                        if (seg !== sgs[j])
                            $display("FAIL scan_1234: an_n=%b got seg=%b, required %b", an_n, seg, sgs[j]);
                        else pass_cnt++;
                    end
                end
            end
            if (frame_start === 1'b1) begin
                if (last >= 0) begin
                    total_cnt++;
                    if (c - last != 16)
                        $display("FAIL frame_period: got %0d cycles, required 16", c - last);
                    else pass_cnt++;
                end
                last = c;
            end
        end
    endtask

    task automatic test_decode();
        for (int h = 0; h < 16; h++) begin
            int  n = 0;
            bit  hit = 0;
            logic [15:0] v;
            logic [3:0]  hn;
            hn = 4'(h);
            v = {12'h000, hn};
            do_load(v, 4'h0, 4'h0, 4'h0, 1'b0);
            while (!hit && n < 40) begin
                @(negedge clk);
                n++;
                hit = n >= 2 && an_n == 4'b1110;
            end
            total_cnt++;
            if (!hit) $display("FAIL decode_wait: digit 0 not selected within 40 cycles for %h", hn);
            else if (seg !== TBL[h] || seg !== exp_seg)
                $display("FAIL decode_%h: got seg=%b, required %b", hn, seg, TBL[h]);
            else pass_cnt++;
        end
    endtask

    task automatic test_lz();
        logic [6:0] want;
        do_load(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1);
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            want = an_n == 4'b1101 ? 7'b0010010 : an_n == 4'b1110 ? 7'b1000000 : 7'b1111111;
            total_cnt++;
            if (seg !== want || seg !== exp_seg || an_n !== exp_an)
                $display("FAIL lz_0050: an_n=%b got seg=%b, required %b", an_n, seg, want);
            else pass_cnt++;
        end
        do_load(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            want = an_n == 4'b1110 ? 7'b1000000 : 7'b1111111;
            total_cnt++;
            if (seg !== want || seg !== exp_seg || an_n !== exp_an)
                $display("FAIL lz_0000: an_n=%b got seg=%b, required %b", an_n, seg, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_blink_dp();
        int lit = 0;
        int dark = 0;
        do_load(16'h1234, 4'h0, 4'b0001, 4'b0010, 1'b0);
        @(negedge clk);
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({seg, dp_n, an_n, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs})
                $display("FAIL blink_model: got %b/%b/%b/%b, required %b/%b/%b/%b",
                         seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            else pass_cnt++;
            total_cnt++;
            if ((dp_n === 1'b0) !== (an_n === 4'b1101))
                $display("FAIL dp_select: an_n=%b got dp_n=%b", an_n, dp_n);
            else pass_cnt++;
            if (an_n == 4'b1110) begin
                if (seg == 7'b1111111) dark++;
                else lit++;
            end
        end
        total_cnt++;
        if (lit == 0 || dark == 0)
            $display("FAIL blink_alternate: digit 0 lit %0d dark %0d cycles, required both nonzero", lit, dark);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            int hold = $urandom_range(5, 30);
            do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                total_cnt++;
                if ({seg, dp_n, an_n, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs})
                    $display("FAIL random_%0d: got %b/%b/%b/%b, required %b/%b/%b/%b", t,
                             seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_load(16'h9876, 4'h0, 4'h0, 4'hf, 1'b0);
        while (an_n !== 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (an_n !== 4'b1011) begin
            $display("FAIL reset_mid_wait: an_n=1011 not seen within 40 cycles");
        end else begin
            pass_cnt++;
            reset = 1'b1;
            @(negedge clk);
            total_cnt++;
            if ({seg, dp_n, an_n, frame_start} !== {7'b1111111, 1'b1, 4'b1111, 1'b0})
                $display("FAIL reset_mid_off: got %b/%b/%b/%b, required 1111111/1/1111/0",
                         seg, dp_n, an_n, frame_start);
            else pass_cnt++;
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            total_cnt++;
            if ({seg, dp_n, an_n, frame_start} !== {7'b1000000, 1'b1, 4'b1110, 1'b1})
                $display("FAIL reset_mid_restart: got %b/%b/%b/%b, required 1000000/1/1110/1",
                         seg, dp_n, an_n, frame_start);
            else pass_cnt++;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                total_cnt++;
                if ({seg, dp_n, an_n, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs} || seg !== 7'b1000000)
                    $display("FAIL reset_mid_zero: got %b/%b/%b/%b, required %b/%b/%b/%b",
                             seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_lz();
        test_blink_dp();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
